// File: rtl/pc_sequencer.sv
// Flow-control sequencer for the 8-bit program counter: FETCH/EXEC/HALT FSM,
// next-address selection and a small return-address stack.
module pc_sequencer #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic [WIDTH-1:0] PC,
    input  logic             Instr_Valid,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Target,
    input  logic             Zero,
    input  logic             Run,
    output logic [WIDTH-1:0] Next_PC,
    output logic             Fetch_En,
    output logic             Exec_En,
    output logic             Halted,
    output logic [3:0]       Depth,
    output logic             Stack_Err
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] FULL_D = 4'(STACK_DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BNE  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t           state;
    logic [WIDTH-1:0] cur_pc;
    logic [WIDTH-1:0] stack [STACK_DEPTH];
    logic [WIDTH-1:0] cur_inc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] top;
    logic [3:0]       depth_m1;
    logic             full;
    logic             empty;

    assign cur_inc  = cur_pc + WIDTH'(1);
    assign pc_inc   = PC + WIDTH'(1);
    assign depth_m1 = Depth - 4'd1;
    assign top      = stack[depth_m1[AW-1:0]];
    assign full     = (Depth == FULL_D);
    assign empty    = (Depth == 4'd0);

    // EXEC never looks at PC: the counter reloads mid-EXEC on the falling edge.
    always_comb begin
        Next_PC = PC;
        case (state)
            HALT:  Next_PC = Run ? pc_inc : PC;
            EXEC: begin
                case (Op)
                    OP_JMP:  Next_PC = Target;
                    OP_BEQ:  Next_PC = Zero ? Target : cur_inc;
                    OP_BNE:  Next_PC = Zero ? cur_inc : Target;
                    OP_CALL: Next_PC = full ? cur_inc : Target;
                    OP_RET:  Next_PC = empty ? cur_inc : top;
                    OP_HALT: Next_PC = cur_pc;
                    default: Next_PC = cur_inc;
                endcase
            end
            default: Next_PC = PC;
        endcase
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state     <= FETCH;
            cur_pc    <= '0;
            Depth     <= 4'd0;
            Stack_Err <= 1'b0;
            Fetch_En  <= 1'b1;
            Exec_En   <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (Instr_Valid) begin
                        state    <= EXEC;
                        cur_pc   <= PC;
                        Fetch_En <= 1'b0;
                        Exec_En  <= 1'b1;
                    end
                end
                EXEC: begin
                    Exec_En <= 1'b0;
                    if (Op == OP_HALT) begin
                        state  <= HALT;
                        Halted <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        Fetch_En <= 1'b1;
                    end
                    if (Op == OP_CALL) begin
                        if (full) Stack_Err <= 1'b1;
                        else      Depth     <= Depth + 4'd1;
                    end
                    if (Op == OP_RET) begin
                        if (empty) Stack_Err <= 1'b1;
                        else       Depth     <= depth_m1;
                    end
                end
                HALT: begin
                    if (Run) begin
                        state    <= FETCH;
                        Halted   <= 1'b0;
                        Fetch_En <= 1'b1;
                    end
                end
                default: begin
                    state    <= FETCH;
                    Fetch_En <= 1'b1;
                    Exec_En  <= 1'b0;
                    Halted   <= 1'b0;
                end
            endcase
        end
    end

    // Contents need no reset; Depth alone decides which entries are live.
    always_ff @(posedge Clk) begin
        if (!Clear && state == EXEC && Op == OP_CALL && !full)
            stack[Depth[AW-1:0]] <= cur_inc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer, with a behavioural falling-edge PC register.
module tb_pc_sequencer;
    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BNE  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_SEQ7 = 3'b111;

    logic       Clk = 1'b0;
    logic       Clear;
    logic [7:0] PC;
    logic       Instr_Valid;
    logic [2:0] Op;
    logic [7:0] Target;
    logic       Zero;
    logic       Run;
    logic [7:0] Next_PC;
    logic       Fetch_En, Exec_En, Halted, Stack_Err;
    logic [3:0] Depth;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .Clk(Clk), .Clear(Clear), .PC(PC), .Instr_Valid(Instr_Valid), .Op(Op),
        .Target(Target), .Zero(Zero), .Run(Run), .Next_PC(Next_PC),
        .Fetch_En(Fetch_En), .Exec_En(Exec_En), .Halted(Halted),
        .Depth(Depth), .Stack_Err(Stack_Err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk or posedge Clear)
        if (Clear) PC <= 8'h00;
        else       PC <= Next_PC;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Starts and ends 1 time unit after a rising edge, in FETCH.
    task automatic do_instr(input logic [2:0] op, input logic [7:0] tgt, input logic z);
        Instr_Valid = 1'b1;
        @(posedge Clk); #1;
        Instr_Valid = 1'b0;
        Op = op; Target = tgt; Zero = z;
        @(posedge Clk); #1;
        Op = OP_SEQ; Target = 8'h00; Zero = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        #2;
        @(posedge Clk); #2;
        Clear = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        do_instr(OP_JMP, 8'h01, 1'b0);
        do_instr(OP_CALL, 8'h55, 1'b0);
        checks++;
        if (PC !== 8'h55 || Depth !== 4'd1) begin
            errors++;
            $display("FAIL reset_pre: PC=%h Depth=%0d, required 55/1", PC, Depth);
        end
        #2;
        Clear = 1'b1;
        #1;
        checks++;
        if (Next_PC !== 8'h00 || PC !== 8'h00 || Fetch_En !== 1'b1 || Exec_En !== 1'b0 ||
            Halted !== 1'b0 || Depth !== 4'd0 || Stack_Err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: Next_PC=%h PC=%h F=%b E=%b H=%b D=%0d Err=%b, required 00/00/1/0/0/0/0",
                     Next_PC, PC, Fetch_En, Exec_En, Halted, Depth, Stack_Err);
        end
        @(posedge Clk); #2;
        Clear = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_seq_wrap();
        do_instr(OP_JMP, 8'hFE, 1'b0);
        checks++;
        if (PC !== 8'hFE) begin
            errors++; $display("FAIL jmp_fe: PC=%h, required FE", PC);
        end
        Instr_Valid = 1'b1;
        @(posedge Clk); #1;
        Instr_Valid = 1'b0; Op = OP_SEQ;
        checks++;
        if (Exec_En !== 1'b1 || PC !== 8'hFE) begin
            errors++; $display("FAIL seq_exec_cycle: Exec_En=%b PC=%h, required 1/FE", Exec_En, PC);
        end
        @(posedge Clk); #1;
        checks++;
        if (PC !== 8'hFF || Fetch_En !== 1'b1) begin
            errors++; $display("FAIL seq_ff: PC=%h Fetch_En=%b, required FF/1", PC, Fetch_En);
        end
        do_instr(OP_SEQ7, 8'h00, 1'b0);
        checks++;
        if (PC !== 8'h00) begin
            errors++; $display("FAIL seq_wrap: PC=%h, required 00", PC);
        end
        for (int i = 0; i < 3; i++) begin
            Op = OP_JMP; Target = 8'h99; Run = 1'b1;
            @(posedge Clk); #1;
            checks++;
            if (PC !== 8'h00 || Fetch_En !== 1'b1) begin
                errors++; $display("FAIL fetch_stall%0d: PC=%h Fetch_En=%b, required 00/1", i, PC, Fetch_En);
            end
        end
        Op = OP_SEQ; Target = 8'h00; Run = 1'b0;
        do_instr(OP_SEQ, 8'h00, 1'b0);
        checks++;
        if (PC !== 8'h01) begin
            errors++; $display("FAIL seq_after_stall: PC=%h, required 01", PC);
        end
    endtask

    task automatic test_branches();
        do_instr(OP_JMP, 8'h10, 1'b0);
        do_instr(OP_BEQ, 8'h40, 1'b1);
        checks++;
        if (PC !== 8'h40) begin
            errors++; $display("FAIL beq_taken: PC=%h, required 40", PC);
        end
        do_instr(OP_JMP, 8'h10, 1'b0);
        do_instr(OP_BEQ, 8'h40, 1'b0);
        checks++;
        if (PC !== 8'h11) begin
            errors++; $display("FAIL beq_not_taken: PC=%h, required 11", PC);
        end
        do_instr(OP_JMP, 8'h10, 1'b0);
        do_instr(OP_BNE, 8'h40, 1'b0);
        checks++;
        if (PC !== 8'h40) begin
            errors++; $display("FAIL bne_taken: PC=%h, required 40", PC);
        end
        do_instr(OP_BNE, 8'h80, 1'b1);
        checks++;
        if (PC !== 8'h41) begin
            errors++; $display("FAIL bne_not_taken: PC=%h, required 41", PC);
        end
    endtask

    task automatic test_calls();
        logic [7:0] src [4];
        logic [7:0] tgt [4];
        logic [7:0] ret [4];
        src = '{8'h01, 8'h21, 8'h31, 8'h41};
        tgt = '{8'h20, 8'h30, 8'h40, 8'h50};
        ret = '{8'h42, 8'h32, 8'h22, 8'h02};
        for (int i = 0; i < 4; i++) begin
            do_instr(OP_JMP, src[i], 1'b0);
            do_instr(OP_CALL, tgt[i], 1'b0);
            checks++;
            if (PC !== tgt[i] || Depth !== 4'(i + 1)) begin
                errors++;
                $display("FAIL call%0d: PC=%h Depth=%0d, required %h/%0d", i, PC, Depth, tgt[i], i + 1);
            end
        end
        do_instr(OP_JMP, 8'h51, 1'b0);
        do_instr(OP_CALL, 8'h60, 1'b0);
        checks++;
        if (PC !== 8'h52 || Stack_Err !== 1'b1 || Depth !== 4'd4) begin
            errors++;
            $display("FAIL call_overflow: PC=%h Err=%b Depth=%0d, required 52/1/4", PC, Stack_Err, Depth);
        end
        for (int i = 0; i < 4; i++) begin
            do_instr(OP_RET, 8'hAA, 1'b0);
            checks++;
            if (PC !== ret[i] || Depth !== 4'(3 - i)) begin
                errors++;
                $display("FAIL ret%0d: PC=%h Depth=%0d, required %h/%0d", i, PC, Depth, ret[i], 3 - i);
            end
        end
        checks++;
        if (Stack_Err !== 1'b1) begin
            errors++; $display("FAIL err_sticky_calls: Stack_Err=%b, required 1", Stack_Err);
        end
    endtask

    task automatic test_underflow();
        pulse_clear();
        checks++;
        if (Stack_Err !== 1'b0 || Depth !== 4'd0) begin
            errors++; $display("FAIL clear_err: Err=%b Depth=%0d, required 0/0", Stack_Err, Depth);
        end
        do_instr(OP_JMP, 8'h07, 1'b0);
        do_instr(OP_RET, 8'h33, 1'b0);
        checks++;
        if (PC !== 8'h08 || Stack_Err !== 1'b1 || Depth !== 4'd0) begin
            errors++;
            $display("FAIL ret_underflow: PC=%h Err=%b Depth=%0d, required 08/1/0", PC, Stack_Err, Depth);
        end
        do_instr(OP_SEQ, 8'h00, 1'b0);
        do_instr(OP_JMP, 8'h70, 1'b0);
        checks++;
        if (PC !== 8'h70 || Stack_Err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: PC=%h Err=%b, required 70/1", PC, Stack_Err);
        end
        pulse_clear();
        checks++;
        if (Stack_Err !== 1'b0) begin
            errors++; $display("FAIL err_cleared: Err=%b, required 0", Stack_Err);
        end
    endtask

    task automatic test_halt();
        do_instr(OP_JMP, 8'h30, 1'b0);
        do_instr(OP_HALT, 8'h77, 1'b0);
        checks++;
        if (Halted !== 1'b1 || Fetch_En !== 1'b0 || PC !== 8'h30) begin
            errors++; $display("FAIL halt_enter: Halted=%b Fetch_En=%b PC=%h, required 1/0/30", Halted, Fetch_En, PC);
        end
        for (int i = 0; i < 10; i++) begin
            Instr_Valid = 1'b1; Op = OP_JMP; Target = 8'h99;
            @(posedge Clk); #1;
            checks++;
            if (PC !== 8'h30 || Halted !== 1'b1) begin
                errors++; $display("FAIL halt_hold%0d: PC=%h Halted=%b, required 30/1", i, PC, Halted);
            end
        end
        Instr_Valid = 1'b0; Op = OP_SEQ; Target = 8'h00;
        Run = 1'b1;
        #5;
        checks++;
        if (PC !== 8'h31 || Halted !== 1'b1) begin
            errors++; $display("FAIL run_pc: PC=%h Halted=%b, required 31/1", PC, Halted);
        end
        @(posedge Clk); #1;
        Run = 1'b0;
        checks++;
        if (Fetch_En !== 1'b1 || Halted !== 1'b0 || PC !== 8'h31) begin
            errors++; $display("FAIL run_resume: Fetch_En=%b Halted=%b PC=%h, required 1/0/31", Fetch_En, Halted, PC);
        end
        do_instr(OP_SEQ, 8'h00, 1'b0);
        checks++;
        if (PC !== 8'h32) begin
            errors++; $display("FAIL after_resume: PC=%h, required 32", PC);
        end
    endtask

    task automatic test_clear_mid();
        do_instr(OP_JMP, 8'h01, 1'b0);
        do_instr(OP_CALL, 8'h20, 1'b0);
        do_instr(OP_CALL, 8'h60, 1'b0);
        checks++;
        if (Depth !== 4'd2 || PC !== 8'h60) begin
            errors++; $display("FAIL clear_mid_pre: Depth=%0d PC=%h, required 2/60", Depth, PC);
        end
        Instr_Valid = 1'b1;
        @(posedge Clk); #1;
        Instr_Valid = 1'b0; Op = OP_CALL; Target = 8'h70;
        #1;
        Clear = 1'b1;
        #1;
        checks++;
        if (Depth !== 4'd0 || PC !== 8'h00 || Fetch_En !== 1'b1 || Exec_En !== 1'b0 || Next_PC !== 8'h00) begin
            errors++;
            $display("FAIL clear_mid: Depth=%0d PC=%h F=%b E=%b Next_PC=%h, required 0/00/1/0/00",
                     Depth, PC, Fetch_En, Exec_En, Next_PC);
        end
        @(posedge Clk); #2;
        Clear = 1'b0;
        Op = OP_SEQ; Target = 8'h00;
        @(posedge Clk); #1;
        checks++;
        if (Depth !== 4'd0 || PC !== 8'h00 || Fetch_En !== 1'b1) begin
            errors++; $display("FAIL clear_mid_after: Depth=%0d PC=%h F=%b, required 0/00/1", Depth, PC, Fetch_En);
        end
        do_instr(OP_RET, 8'h44, 1'b0);
        checks++;
        if (PC !== 8'h01 || Stack_Err !== 1'b1) begin
            errors++; $display("FAIL clear_no_push: PC=%h Err=%b, required 01/1", PC, Stack_Err);
        end
    endtask

    initial begin
        Clear = 1'b1; Instr_Valid = 1'b0; Op = OP_SEQ; Target = 8'h00; Zero = 1'b0; Run = 1'b0;
        #12;
        Clear = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (PC !== 8'h00 || Fetch_En !== 1'b1 || Depth !== 4'd0 || Stack_Err !== 1'b0) begin
            errors++;
            $display("FAIL power_on: PC=%h F=%b D=%0d Err=%b, required 00/1/0/0", PC, Fetch_En, Depth, Stack_Err);
        end
        test_reset();
        test_seq_wrap();
        test_branches();
        test_calls();
        test_underflow();
        test_halt();
        test_clear_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
